// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - requester-side and downstream bus signals of bus_rr_arbiter
interface bus_rr_arbiter_if #(
  parameter int NREQ = 2
);
  logic [32*NREQ-1:0] m_a;
  logic [32*NREQ-1:0] m_d;
  logic [32*NREQ-1:0] m_spo;
  logic [NREQ-1:0]    m_we;
  logic [NREQ-1:0]    m_rd;
  logic [NREQ-1:0]    m_ready;
  logic [31:0]        s_a;
  logic [31:0]        s_d;
  logic [31:0]        s_spo;
  logic               s_we;
  logic               s_rd;
  logic               s_ready;

  // slave: the arbiter's view; master: requesters plus downstream memory
  modport slave (
    input  m_a, m_d, m_we, m_rd, s_spo, s_ready,
    output m_spo, m_ready, s_a, s_d, s_we, s_rd
  );
  modport master (
    output m_a, m_d, m_we, m_rd, s_spo, s_ready,
    input  m_spo, m_ready, s_a, s_d, s_we, s_rd
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one memory bus among NREQ requesters
// Optional watchdog: BUS_RR_ARBITER_TIMEOUT_EN
module bus_rr_arbiter #(
  parameter int NREQ           = 2,
  parameter int GW             = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_rr_arbiter_if.slave   bus,
  output logic [GW-1:0]     grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state, state_nx;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      sel, first_any, first_hi;
  logic               any_req, hi_req;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    ready_q;
  logic [32*NREQ-1:0] spo_q;
  logic [31:0]        s_a_q, s_d_q, sel_a, sel_d;
  logic               s_we_q, s_rd_q, sel_we, sel_rd, op_rd;
  logic               done, to_hit;

  // A requester whose completion pulse is showing has not yet had a chance to drop
  assign req = (bus.m_we | bus.m_rd) & ~ready_q;

  always_comb begin
    any_req   = 1'b0;
    hi_req    = 1'b0;
    first_any = '0;
    first_hi  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req   = 1'b1;
        first_any = GW'(i);
      end
      if (req[i] && (GW'(i) >= ptr)) begin
        hi_req   = 1'b1;
        first_hi = GW'(i);
      end
    end
    sel = hi_req ? first_hi : first_any;
  end

  always_comb begin
    sel_a  = '0;
    sel_d  = '0;
    sel_we = 1'b0;
    sel_rd = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == GW'(i)) begin
        sel_a  = bus.m_a[32*i +: 32];
        sel_d  = bus.m_d[32*i +: 32];
        sel_we = bus.m_we[i];
        sel_rd = bus.m_rd[i] & ~bus.m_we[i];
      end
    end
  end

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign to_hit = (state == S_WAIT) && !bus.s_ready &&
                  (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (state == S_WAIT && !bus.s_ready)
        wd_cnt <= wd_cnt + 32'd1;
      if (to_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = (state == S_WAIT) && (bus.s_ready || to_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      grant   <= '0;
      s_a_q   <= '0;
      s_d_q   <= '0;
      s_we_q  <= 1'b0;
      s_rd_q  <= 1'b0;
      op_rd   <= 1'b0;
      ready_q <= '0;
      spo_q   <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant  <= sel;
            ptr    <= (sel == GW'(NREQ - 1)) ? '0 : sel + GW'(1);
            s_a_q  <= sel_a;
            s_d_q  <= sel_d;
            s_we_q <= sel_we;
            s_rd_q <= sel_rd;
            op_rd  <= sel_rd;
          end
        end
        S_ISSUE: begin
          s_we_q <= 1'b0;
          s_rd_q <= 1'b0;
        end
        S_WAIT: begin
          if (done) begin
            for (int i = 0; i < NREQ; i++) begin
              if (grant == GW'(i)) begin
                ready_q[i] <= 1'b1;
                if (op_rd)
                  spo_q[32*i +: 32] <= to_hit ? 32'hDEADBEEF : bus.s_spo;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_a     = s_a_q;
  assign bus.s_d     = s_d_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_rd    = s_rd_q;
  assign bus.m_ready = ready_q;
  assign bus.m_spo   = spo_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  localparam int NREQ = 2;
  localparam int GW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [GW-1:0] grant;
  logic          busy;
  logic          timeout_err;
  int            n_cmp = 0;
  int            n_fail = 0;

  bus_rr_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_rr_arbiter #(.NREQ(NREQ), .GW(GW), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_a = '0; bus.m_d = '0; bus.m_we = '0; bus.m_rd = '0;
    bus.s_spo = '0; bus.s_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.s_a, bus.s_d, bus.s_we, bus.s_rd} !== 66'd0) begin
      n_fail++; $display("FAIL reset_s_bus got %h want 0", {bus.s_a, bus.s_d, bus.s_we, bus.s_rd});
    end
    n_cmp++;
    if ({bus.m_spo, bus.m_ready, grant, busy, timeout_err} !== 70'd0) begin
      n_fail++; $display("FAIL reset_m_side got %h want 0", {bus.m_spo, bus.m_ready, grant, busy, timeout_err});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bus.m_rd = 2'b01; bus.m_a[31:0] = 32'h0000_1000;
    tick();
    n_cmp++;
    if (bus.s_rd !== 1'b1 || bus.s_we !== 1'b0 || bus.s_a !== 32'h0000_1000) begin
      n_fail++; $display("FAIL read_issue got rd=%b we=%b a=%h want 1 0 00001000", bus.s_rd, bus.s_we, bus.s_a);
    end
    tick();
    n_cmp++;
    if (bus.s_rd !== 1'b0 || bus.m_ready !== 2'b00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL read_wait1 got rd=%b rdy=%b busy=%b want 0 00 1", bus.s_rd, bus.m_ready, busy);
    end
    tick();
    bus.s_ready = 1'b1; bus.s_spo = 32'h1234_5678;
    tick();
    n_cmp++;
    if (bus.m_ready !== 2'b01 || bus.m_spo[31:0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL read_done got rdy=%b spo=%h want 01 12345678", bus.m_ready, bus.m_spo[31:0]);
    end
    bus.s_ready = 1'b0;
    tick();
    bus.m_rd = 2'b00;
    n_cmp++;
    if (bus.m_ready !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL read_no_repeat got rdy=%b busy=%b want 00 0", bus.m_ready, busy);
    end
    tick();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.m_rd = 2'b11; bus.s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (grant !== GW'(k % 2) || bus.s_rd !== 1'b1) begin
        n_fail++; $display("FAIL rr_grant%0d got %0d rd=%b want %0d 1", k, grant, bus.s_rd, k % 2);
      end
      bus.s_spo = 32'hA000_0000 + 32'(k);
      tick();
      tick();
      n_cmp++;
      if (bus.m_ready !== 2'(1 << (k % 2)) ||
          bus.m_spo[32*(k%2) +: 32] !== 32'hA000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL rr_done%0d got rdy=%b spo=%h want %b %h", k, bus.m_ready,
                           bus.m_spo[32*(k%2) +: 32], 2'(1 << (k % 2)), 32'hA000_0000 + 32'(k));
      end
    end
    bus.m_rd = 2'b00;
    tick();
  endtask

  task automatic test_write();
    bus.m_we = 2'b10; bus.m_rd = 2'b10;
    bus.m_d[63:32] = 32'hCAFE_F00D; bus.m_a[63:32] = 32'h8000_0004;
    bus.s_ready = 1'b1; bus.s_spo = 32'hBADB_AD00;
    tick();
    n_cmp++;
    if (bus.s_we !== 1'b1 || bus.s_rd !== 1'b0 || bus.s_d !== 32'hCAFE_F00D ||
        bus.s_a !== 32'h8000_0004 || grant !== 2'd1) begin
      n_fail++; $display("FAIL wr_issue got we=%b rd=%b d=%h a=%h g=%0d want 1 0 cafef00d 80000004 1",
                         bus.s_we, bus.s_rd, bus.s_d, bus.s_a, grant);
    end
    tick();
    n_cmp++;
    if (bus.s_we !== 1'b0) begin
      n_fail++; $display("FAIL wr_we_drop got %b want 0", bus.s_we);
    end
    tick();
    n_cmp++;
    if (bus.m_ready !== 2'b10 || bus.m_spo[63:32] !== 32'hA000_0003) begin
      n_fail++; $display("FAIL wr_done got rdy=%b spo=%h want 10 a0000003", bus.m_ready, bus.m_spo[63:32]);
    end
    bus.m_we = 2'b00; bus.m_rd = 2'b00;
    tick();
  endtask

  task automatic test_async_reset();
    bus.s_ready = 1'b0; bus.m_rd = 2'b01;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1 || grant !== 2'd0) begin
      n_fail++; $display("FAIL ar_pre busy=%b g=%0d want 1 0", busy, grant);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.s_a, bus.s_d, bus.s_we, bus.s_rd, bus.m_spo, bus.m_ready, grant, busy, timeout_err} !== 136'd0) begin
      n_fail++; $display("FAIL ar_outputs got %h want 0",
                         {bus.s_a, bus.s_d, bus.s_we, bus.s_rd, bus.m_spo, bus.m_ready, grant, busy, timeout_err});
    end
    @(negedge clk);
    bus.m_rd = 2'b11;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 2'd0 || bus.s_rd !== 1'b1 || bus.m_ready !== 2'b00) begin
      n_fail++; $display("FAIL ar_regrant got g=%0d rd=%b rdy=%b want 0 1 00", grant, bus.s_rd, bus.m_ready);
    end
    bus.s_ready = 1'b1; bus.s_spo = 32'h0000_0055;
    tick();
    tick();
    bus.m_rd = 2'b00;
    n_cmp++;
    if (bus.m_ready !== 2'b01 || bus.m_spo[31:0] !== 32'h0000_0055) begin
      n_fail++; $display("FAIL ar_done got rdy=%b spo=%h want 01 00000055", bus.m_ready, bus.m_spo[31:0]);
    end
    tick();
  endtask

  task automatic test_drop_reraise();
    int pulses0;
    pulses0 = 0;
    bus.m_rd = 2'b10; bus.s_ready = 1'b1;
    tick();
    bus.m_rd[0] = 1'b1;
    n_cmp++;
    if (grant !== 2'd1) begin
      n_fail++; $display("FAIL dr_first got %0d want 1", grant);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.m_ready !== 2'b10) begin
      n_fail++; $display("FAIL dr_done1 got %b want 10", bus.m_ready);
    end
    bus.m_rd[1] = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 2'd0 || bus.s_rd !== 1'b1) begin
      n_fail++; $display("FAIL dr_second got g=%0d rd=%b want 0 1", grant, bus.s_rd);
    end
    tick();
    tick();
    if (bus.m_ready[0] === 1'b1) pulses0++;
    bus.m_rd[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.m_ready[0] === 1'b1) pulses0++;
    end
    n_cmp++;
    if (pulses0 !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dr_pulses got %0d busy=%b want 1 0", pulses0, busy);
    end
  endtask

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    bus.s_ready = 1'b0; bus.m_rd = 2'b01;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.m_ready !== 2'b00) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_fail++; $display("FAIL to_early got %0d want 0", early);
    end
    tick();
    bus.m_rd = 2'b00;
    n_cmp++;
    if (bus.m_ready !== 2'b01 || bus.m_spo[31:0] !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_done got rdy=%b spo=%h err=%b want 01 deadbeef 1",
                         bus.m_ready, bus.m_spo[31:0], timeout_err);
    end
    tick(); tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_sticky got err=%b busy=%b want 1 0", timeout_err, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_async_reset();
    test_drop_reraise();
`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one downstream memory/MMIO bus (the a/d/we/rd/spo/ready port of the address high mapper) between NREQ masters, e.g. CPU instruction fetch, CPU data and DMA.
- Round-robin grant; one transaction outstanding at a time.
- Registered downstream outputs; per-requester read-data holding registers and a single-cycle completion pulse.

Parameters:
- NREQ, 2, number of requesters (2..4).
- GW, 2, width of grant index; must satisfy 2^GW >= NREQ.
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_a  in  32*NREQ  requester addresses; requester i uses bits [32i+31:32i].
- m_d  in  32*NREQ  requester write data, same packing.
- m_we  in  NREQ  write request per requester; level, held until its m_ready.
- m_rd  in  NREQ  read request per requester; level, held until its m_ready.
- m_spo  out  32*NREQ  read data per requester.
- m_ready  out  NREQ  completion pulse per requester.
- s_a  out  32  downstream address.
- s_d  out  32  downstream write data.
- s_we  out  1  downstream write strobe.
- s_rd  out  1  downstream read strobe.
- s_spo  in  32  downstream read data.
- s_ready  in  1  downstream done.
- grant  out  GW  index of the last/current granted requester.
- busy  out  1  high in ISSUE or WAIT.
- timeout_err  out  1  sticky watchdog flag (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, including s_a, s_d, s_we, s_rd, m_spo, m_ready, grant, busy and timeout_err. State goes to IDLE and the RR pointer to 0. Reset mid-transaction abandons it with no m_ready pulse.
- Request of requester i: m_we[i] | m_rd[i]. If both are high, it is treated as a write and rd is ignored.
- IDLE:
  - If any request is pending, select the first requester at or after the pointer, wrapping modulo NREQ.
  - Register s_a, s_d, s_we, s_rd and grant from it; go to ISSUE.
  - Set the pointer to (selected+1) mod NREQ.
- ISSUE: s_we/s_rd are high for exactly this one cycle. Next cycle they drop to 0 and the state goes to WAIT. s_a and s_d hold their values until the next grant.
- WAIT:
  - s_ready is first sampled in the cycle after ISSUE. Slaves needing more than one cycle must drive s_ready=0 in that cycle.
  - On the first cycle with s_ready=1:
    - For a read, latch s_spo into m_spo[grant]. For a write, m_spo is unchanged.
    - Pulse m_ready[grant]=1 for one cycle and return to IDLE.
- Requester rules:
  - The requester must drop its request in the cycle after its m_ready pulse.
  - If it still appears asserted in the following IDLE cycle, it is arbitrated as a new request.
- Latency: minimum 3 cycles from request to m_ready (IDLE, ISSUE, WAIT with s_ready=1), with m_ready high in the cycle after that WAIT.
- m_spo[i] holds its value until requester i's next read completes.
- Requests changing while not granted are sampled only in IDLE.
- No starvation: with all NREQ requesting continuously, each is served exactly once per NREQ transactions.
- busy = (state != IDLE).

Optional Feature:
- Macro: BUS_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle with s_ready=0.
  - When it reaches TIMEOUT_CYCLES, the transaction is forced complete: a read returns m_spo = 32'hDEADBEEF, m_ready pulses and the state returns to IDLE.
  - timeout_err is set and stays set until reset.
- Undefined: no counter; WAIT lasts indefinitely; timeout_err is constant 0.

Test Plan:
- Single read: m_rd[0]=1, m_a[31:0]=0x00001000, slave returns 0x12345678 with s_ready 2 cycles after ISSUE. Required: s_rd high exactly 1 cycle with s_a=0x00001000; m_ready[0] pulses once; m_spo[31:0]=0x12345678.
- Round-robin fairness: NREQ=2, both request continuously, slave ready in 1 cycle. Required: grant sequence 0,1,0,1; each m_ready pulse goes to the alternating requester.
- Write: m_we[1]=1, m_rd[1]=1, m_d=0xCAFEF00D, a=0x80000004. Required: s_we=1, s_rd=0, s_d=0xCAFEF00D; m_spo[63:32] unchanged.
- Async reset while in WAIT. Required: all outputs 0 immediately; no m_ready pulse; the next request is granted starting from requester 0.
- With BUS_RR_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserts s_ready. Required: m_ready pulses after 8 WAIT cycles, m_spo=0xDEADBEEF, timeout_err=1 and sticky.
- Request dropped and re-raised the same cycle as grant to another requester. Required: it is served on the next IDLE, with no duplicate m_ready.
